// File: rtl/std_fp_mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Sizing helper keeps a 1-bit id even when only one requester exists.
package std_fp_mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  localparam int MULT_LATENCY    = 3;
  localparam int MULT_RESET_HOLD = 2;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/std_fp_mult_arbiter_rr.sv
// Combinational round-robin pick, zero latency, no backpressure of its own.
// Search starts one past the last winner; the pointer register lives in the parent.
module std_rr_arbiter
  import std_fp_mult_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last) + i) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/std_fp_mult_arbiter.sv
// Round-robin share of one pipelined multiplier; grant to resp_valid is 4 cycles, one op per 5 cycles.
// Holds the response until the owner's resp_ready with no new grant meanwhile; FP_MULT_ARB_WATCHDOG_EN adds an ISSUE timeout.
module std_fp_mult_arbiter
  import std_fp_mult_arb_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  WIDTH       = 32,
  parameter int  WDOG_CYCLES = 8,
  localparam int IDW         = id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_left,
  input  logic [NUM_REQ*WIDTH-1:0]   req_right,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [IDW-1:0]             resp_id,
  output logic                       resp_err,
  output logic [WIDTH-1:0]           mult_left,
  output logic [WIDTH-1:0]           mult_right,
  output logic                       mult_go,
  output logic                       mult_reset,
  input  logic [WIDTH-1:0]           mult_out,
  input  logic                       mult_done
);

  arb_state_t       state, state_nxt;
  logic [IDW-1:0]   last_grant, owner;
  logic [WIDTH-1:0] op_left, op_right, data_q;
  logic [1:0]       rst_cnt;
  logic [NUM_REQ-1:0] pick;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             grant_fire, done_fire, resp_fire, wdog_fire;
  logic [WIDTH-1:0] left_arr  [NUM_REQ];
  logic [WIDTH-1:0] right_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign left_arr[i]  = req_left[i*WIDTH +: WIDTH];
    assign right_arr[i] = req_right[i*WIDTH +: WIDTH];
  end

  std_rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_rr (
    .req       (req_valid),
    .last      (last_grant),
    .grant     (pick),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign mult_reset = (rst_cnt != 2'd0);
  assign mult_left  = op_left;
  assign mult_right = op_right;
  assign resp_data  = data_q;
  assign resp_id    = owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    mult_go    = 1'b0;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    resp_fire  = 1'b0;
    case (state)
      IDLE: begin
        // No grant while the multiplier is still being held in reset.
        if (!mult_reset && pick_any) begin
          req_ready  = pick;
          grant_fire = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        mult_go = 1'b1;
        if (mult_done) begin
          done_fire = 1'b1;
          state_nxt = RESP;
        end else if (wdog_fire) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) begin
          resp_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= IDW'(NUM_REQ - 1);
      owner      <= '0;
      op_left    <= '0;
      op_right   <= '0;
      data_q     <= '0;
      rst_cnt    <= 2'(MULT_RESET_HOLD);
    end else begin
      if (rst_cnt != 2'd0) rst_cnt <= rst_cnt - 2'd1;
      if (grant_fire) begin
        owner    <= pick_idx;
        op_left  <= left_arr[pick_idx];
        op_right <= right_arr[pick_idx];
      end
      if (done_fire) data_q <= mult_out;
      // A timed-out op returns zero and gives the multiplier a one-cycle reset.
      if (wdog_fire) begin
        data_q  <= '0;
        rst_cnt <= 2'd1;
      end
      if (resp_fire) last_grant <= owner;
    end
  end

`ifdef FP_MULT_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wdog_cnt;
  logic           err_q;

  assign wdog_fire = (state == ISSUE) && !mult_done && (wdog_cnt == WDW'(WDOG_CYCLES - 1));
  assign resp_err  = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant_fire)           wdog_cnt <= '0;
      else if (state == ISSUE)  wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_fire)            err_q <= 1'b1;
      else if (resp_fire)       err_q <= 1'b0;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES > 0);
  assign wdog_fire   = 1'b0;
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_std_fp_mult_arbiter.sv
// Directed bench for std_fp_mult_arbiter with a 3-cycle stub multiplier.
// Define FP_MULT_ARB_WATCHDOG_EN for both RTL and bench to exercise the timeout path.
module tb_std_fp_mult_arbiter;
  import std_fp_mult_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [127:0] req_left, req_right;
  logic [31:0]  resp_data, mult_left, mult_right, mult_out;
  logic [1:0]   resp_id;
  logic         resp_err, mult_go, mult_reset, mult_done;
  logic         stub_dead;
  int           go_cnt = 0;
  int           tests = 0;
  int           fails = 0;

  int           exp_grant [5] = '{1, 2, 4, 8, 1};
  int           exp_prod  [5] = '{3, 9, 15, 21, 3};
  int           exp_id    [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  std_fp_mult_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_left   (req_left),
    .req_right  (req_right),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .mult_left  (mult_left),
    .mult_right (mult_right),
    .mult_go    (mult_go),
    .mult_reset (mult_reset),
    .mult_out   (mult_out),
    .mult_done  (mult_done)
  );

  // Stub multiplier: done on the third consecutive go cycle.
  always @(posedge clk) begin
    if (mult_reset || !mult_go) go_cnt <= 0;
    else                        go_cnt <= go_cnt + 1;
  end
  assign mult_done = mult_go && (go_cnt == MULT_LATENCY - 1) && !stub_dead;
  assign mult_out  = mult_left * mult_right;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] l, input logic [31:0] r);
    req_left[i*32 +: 32]  = l;
    req_right[i*32 +: 32] = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    req_left   = '0;
    req_right  = '0;
    resp_ready = '0;
    stub_dead  = 1'b0;

    // Reset values, with a request already pending
    set_req(0, 32'd6, 32'd7);
    req_valid = 4'b0001;
    @(negedge clk); #1;
    chk("rst_mult_reset", mult_reset, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mult_go", mult_go, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mult_left", mult_left, 0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("hold1_mult_reset", mult_reset, 1);
    chk("hold1_no_grant", req_ready, 0);
    @(negedge clk); #1;
    chk("hold2_mult_reset", mult_reset, 1);
    chk("hold2_no_grant", req_ready, 0);

    // Single request 6*7
    @(negedge clk); #1;
    chk("single_grant", req_ready, 4'b0001);
    chk("single_mult_reset_low", mult_reset, 0);
    @(negedge clk); req_valid = '0; #1;
    chk("single_go", mult_go, 1);
    chk("single_mult_left", mult_left, 6);
    chk("single_mult_right", mult_right, 7);
    chk("single_no_resp_yet", resp_valid, 0);
    repeat (3) @(negedge clk); #1;
    chk("single_resp_valid", resp_valid, 4'b0001);
    chk("single_resp_data", resp_data, 42);
    chk("single_resp_id", resp_id, 0);
    chk("single_go_low", mult_go, 0);
    resp_ready = 4'b1111;
    @(negedge clk); #1;
    chk("single_back_idle", resp_valid, 0);

    // All four valid after reset: order 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_req(i, 32'(2 * i + 1), 32'd3);
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), req_ready, exp_grant[k]);
      repeat (4) @(negedge clk); #1;
      chk($sformatf("rr_resp_valid%0d", k), resp_valid, exp_grant[k]);
      chk($sformatf("rr_resp_data%0d", k), resp_data, exp_prod[k]);
      chk($sformatf("rr_resp_id%0d", k), resp_id, exp_id[k]);
      if (k == 4) req_valid = '0;
      @(negedge clk);
    end

    // Backpressure on requester 1 while requester 2 waits
    set_req(1, 32'd5, 32'd9);
    set_req(2, 32'd4, 32'd11);
    req_valid  = 4'b0110;
    resp_ready = '0;
    #1;
    chk("bp_grant1", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'b0100;
    repeat (3) @(negedge clk); #1;
    chk("bp_resp_valid", resp_valid, 4'b0010);
    chk("bp_resp_data", resp_data, 45);
    chk("bp_resp_id", resp_id, 1);
    resp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk($sformatf("bp_hold_valid%0d", i), resp_valid, 4'b0010);
      chk($sformatf("bp_hold_data%0d", i), resp_data, 45);
      chk($sformatf("bp_no_grant%0d", i), req_ready, 0);
    end
    @(negedge clk); resp_ready = 4'b0010; #1;
    chk("bp_last_valid", resp_valid, 4'b0010);
    @(negedge clk); resp_ready = '0; #1;
    chk("bp_grant2_next", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk); #1;
    chk("bp2_resp_valid", resp_valid, 4'b0100);
    chk("bp2_resp_data", resp_data, 44);
    chk("bp2_resp_id", resp_id, 2);
    resp_ready = 4'b0100;
    @(negedge clk); #1;
    chk("bp2_idle", resp_valid, 0);

    // Reset pulsed in the second ISSUE cycle
    set_req(3, 32'd100, 32'd3);
    req_valid = 4'b1000;
    #1;
    chk("rmid_grant", req_ready, 4'b1000);
    @(negedge clk);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("rmid_go", mult_go, 0);
    chk("rmid_mult_reset", mult_reset, 1);
    chk("rmid_req_ready", req_ready, 0);
    chk("rmid_resp_valid", resp_valid, 0);
    chk("rmid_mult_left", mult_left, 0);
    chk("rmid_resp_data", resp_data, 0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("rmid_hold1", mult_reset, 1);
    chk("rmid_hold1_no_grant", req_ready, 0);
    @(negedge clk); #1;
    chk("rmid_hold2", mult_reset, 1);
    chk("rmid_hold2_no_grant", req_ready, 0);
    @(negedge clk); #1;
    chk("rmid_released", mult_reset, 0);
    chk("rmid_regrant", req_ready, 4'b1000);
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk); #1;
    chk("rmid_resp_valid", resp_valid, 4'b1000);
    chk("rmid_resp_data", resp_data, 300);
    chk("rmid_resp_id", resp_id, 3);
    resp_ready = 4'b1111;
    @(negedge clk);

    // Product wraps to the low 32 bits
    set_req(0, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0001;
    #1;
    chk("ovf_grant", req_ready, 4'b0001);
    @(negedge clk); req_valid = '0; #1;
    chk("ovf_mult_left", mult_left, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk); #1;
    chk("ovf_resp_valid", resp_valid, 4'b0001);
    chk("ovf_resp_data", resp_data, 32'hFFFF_FFFE);
    chk("ovf_resp_id", resp_id, 0);
    @(negedge clk);

    // Multiplier never finishes
    stub_dead  = 1'b1;
    resp_ready = '0;
    set_req(1, 32'd3, 32'd3);
    req_valid = 4'b0010;
    #1;
    chk("wd_grant", req_ready, 4'b0010);
    @(negedge clk); req_valid = '0;
    repeat (7) @(negedge clk); #1;
    chk("wd_issue8_go", mult_go, 1);
    chk("wd_issue8_no_resp", resp_valid, 0);
`ifdef FP_MULT_ARB_WATCHDOG_EN
    @(negedge clk); #1;
    chk("wd_resp_valid", resp_valid, 4'b0010);
    chk("wd_resp_err", resp_err, 1);
    chk("wd_resp_data", resp_data, 0);
    chk("wd_mult_reset_pulse", mult_reset, 1);
    chk("wd_go_low", mult_go, 0);
    @(negedge clk); #1;
    chk("wd_mult_reset_end", mult_reset, 0);
    chk("wd_err_held", resp_err, 1);
    resp_ready = 4'b0010;
    @(negedge clk); #1;
    chk("wd_err_clear", resp_err, 0);
    chk("wd_idle", resp_valid, 0);
`else
    repeat (4) @(negedge clk); #1;
    chk("nowd_still_go", mult_go, 1);
    chk("nowd_no_resp", resp_valid, 0);
    chk("nowd_no_mult_reset", mult_reset, 0);
    chk("nowd_err_zero", resp_err, 0);
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/std_fp_mult_arbiter.md
# std_fp_mult_arbiter

Round-robin controller that shares one 3-cycle pipelined fixed-point multiplier (`std_fp_mult_pipe` family) among `NUM_REQ` requesters. It accepts one operand pair at a time over per-requester valid/ready handshakes and drives the multiplier's `left`/`right`/`go`/`reset`. It waits for `done`, then returns the product to the owning requester. It sits between the multiplier instance and the datapath units that need multiplication but cannot each afford a dedicated multiplier.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 32, operand/result width; matches multiplier `WIDTH`
- `WDOG_CYCLES`, 8, watchdog limit in ISSUE cycles (used only with the watchdog macro)
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse
- `req_left`, `req_right`  in  NUM_REQ×WIDTH  per-requester operands
- `resp_valid`  out  NUM_REQ  one-hot result valid to owner
- `resp_ready`  in  NUM_REQ  per-requester result accept
- `resp_data`  out  WIDTH  product
- `resp_id`  out  max(1,$clog2(NUM_REQ))  owner index
- `resp_err`  out  1  watchdog abort flag
- `mult_left`, `mult_right`  out  WIDTH  multiplier operands
- `mult_go`  out  1  multiplier go
- `mult_reset`  out  1  multiplier synchronous active-high reset
- `mult_out`  in  WIDTH  multiplier result
- `mult_done`  in  1  multiplier done

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: if any `req_valid` is set, the arbiter picks winner g, searching from (last_grant+1) mod NUM_REQ. It asserts `req_ready[g]` for one cycle, latches the operands and g, then goes to ISSUE. With no request it stays in IDLE.
- ISSUE: `mult_go`=1; `mult_left`/`mult_right` hold the latched operands. When `mult_done`=1, `mult_out` is captured into `resp_data` and the FSM goes to RESP.
- RESP: `mult_go`=0; `resp_valid[g]`=1; `resp_id`=g. On `resp_ready[g]`, last_grant←g and the FSM goes to IDLE. `resp_ready` of non-owners is ignored.
- Requesters hold `req_valid` and operands stable until `req_ready`. Dropping `req_valid` before grant is legal; the request is simply not considered.
- Operands pass through unmodified. Signedness is the multiplier's concern.
- `mult_go` is low in IDLE and RESP, so there are ≥2 low cycles between operations. This guarantees the multiplier's done buffer drains before the next start.
- Reset values: all outputs 0, except `mult_reset`=1. last_grant resets to NUM_REQ−1, so requester 0 wins first.
- `reset_n` low mid-operation: the block returns immediately to IDLE, and any pending response is discarded.
- After `reset_n` rises, `mult_reset` stays 1 for 2 more cycles. No grant is issued until `mult_reset` is 0.
- `mult_done` is ignored outside ISSUE.

## Timing
- Cycle 0: grant (`req_ready` pulse, IDLE). Cycles 1–3: ISSUE, `mult_done` expected in cycle 3. Cycle 4: `resp_valid` rises.
- Best-case throughput: one operation per 5 cycles, with `resp_ready` held high.
- A request arriving in RESP is granted in the first IDLE cycle after the response handshake.
- `resp_data`/`resp_id` are stable while `resp_valid` is high.

## Configuration
- `FP_MULT_ARB_WATCHDOG_EN` defined:
  - A counter runs in ISSUE.
  - If `WDOG_CYCLES` ISSUE cycles pass without `mult_done`: `mult_go`←0, `mult_reset` pulses for 1 cycle, RESP is entered with `resp_data`=0 and `resp_err`=1.
  - `resp_err` clears on the response handshake.
- Not defined: no counter; ISSUE waits indefinitely; `resp_err` is tied to 0.

## Structure
- Package `std_fp_mult_arb_pkg`:
  - FSM state enum
  - `MULT_LATENCY`=3
  - `MULT_RESET_HOLD`=2
  - ID-width helper function
- Sub-module `std_rr_arbiter`: combinational round-robin pick from `req_valid` and last_grant, producing a one-hot grant and its index. The pointer register lives in the parent.

## Test plan
- Single request: req0 left=6, right=7 → `req_ready[0]` in cycle 0; `resp_valid[0]` in cycle 4 with `resp_data`=42, `resp_id`=0.
- All four requesters valid continuously after reset → grants in order 0,1,2,3,0; each response carries its own product (operands 2×i+1, 3).
- Backpressure: `resp_ready[1]` held low for 10 cycles → `resp_valid[1]` and data stay stable; req2 is not granted until the handshake, then granted in the next cycle.
- `reset_n` pulsed low in cycle 2 of ISSUE → all outputs 0 and `mult_reset`=1 immediately. `mult_reset` is held for 2 cycles after release. The next request completes with the correct product.
- Overflow wrap: 0xFFFF_FFFF × 2 → `resp_data`=0xFFFF_FFFE (the low `WIDTH` bits passed through).
- Watchdog (macro on): stub multiplier never raises `done` → after 8 ISSUE cycles, `mult_reset` pulses and `resp_err`=1, `resp_data`=0. With the macro off, the FSM stays in ISSUE.
